// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and constants for the FIFO round-robin arbiter.
//   arb_state_e    : arbiter state (idle round-robin search / locked to a port)
//   BEAT_CNT_WIDTH : width of each per-port accepted-beat counter
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   localparam int BEAT_CNT_WIDTH = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority picker. Finds the first asserted request
// starting at start_ptr and searching upwards, wrapping from NUM_PORTS-1 to 0.
// Ports:
//   req       in  NUM_PORTS  request vector
//   start_ptr in  ID_WIDTH   index with highest priority
//   winner    out ID_WIDTH   first requesting index (start_ptr when none)
//   any_req   out 1          at least one request asserted
// ---------------------------------------------------------------------------
module rr_priority_pick #(
   parameter int NUM_PORTS = 4,
   parameter int ID_WIDTH  = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [ID_WIDTH-1:0]  start_ptr,
   output logic [ID_WIDTH-1:0]  winner,
   output logic                 any_req
);

   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_PORTS - 1);

   logic [ID_WIDTH-1:0] idx;

   // Walk the ports in priority order. The wrap is an explicit compare so
   // non-power-of-two port counts rotate correctly.
   always_comb begin
      winner  = start_ptr;
      any_req = 1'b0;
      idx     = start_ptr;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!any_req && req[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
         idx = (idx == LAST_ID) ? '0 : idx + ID_WIDTH'(1);
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_arbiter
// Round-robin arbiter sharing one FIFO write port between NUM_PORTS producers.
// Multi-beat packets (delimited by last_i) are kept atomic: after a non-last
// beat is accepted the arbiter locks to that port until its last beat.
// Forwarding is purely combinational; only state, rr_ptr and lock_id are
// registered.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   data_i       packed per-port payloads, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   valid_i      per-port beat valid
//   last_i       per-port last-beat flag
//   grant_o      per-port beat accepted
//   data_o       selected payload
//   valid_o      beat offered downstream
//   last_o       last flag of the selected beat
//   port_id_o    index of the selected port
//   grant_i      downstream accepts the beat
// Optional (macro FIFO_ARB_BEAT_CNT_EN):
//   cnt_clear_i  synchronous clear of all beat counters
//   beat_cnt_o   per-port saturating accepted-beat counters, 16 bits each
// ---------------------------------------------------------------------------
module fifo_rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int  NUM_PORTS  = 4,
   parameter int  DATA_WIDTH = 32,
   localparam int ID_WIDTH   = $clog2(NUM_PORTS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  data_i,
   input  logic [NUM_PORTS-1:0]             valid_i,
   input  logic [NUM_PORTS-1:0]             last_i,
   output logic [NUM_PORTS-1:0]             grant_o,
   output logic [DATA_WIDTH-1:0]            data_o,
   output logic                             valid_o,
   output logic                             last_o,
   output logic [ID_WIDTH-1:0]              port_id_o,
   input  logic                             grant_i
`ifdef FIFO_ARB_BEAT_CNT_EN
   ,
   input  logic                             cnt_clear_i,
   output logic [NUM_PORTS*BEAT_CNT_WIDTH-1:0] beat_cnt_o
`endif
);

   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_PORTS - 1);

   arb_state_e          state_q, state_d;
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;
   logic [ID_WIDTH-1:0] pick_id;
   logic [ID_WIDTH-1:0] winner;
   logic                any_req;
   logic                xfer;

   function automatic logic [ID_WIDTH-1:0] next_port(input logic [ID_WIDTH-1:0] p);
      return (p == LAST_ID) ? '0 : p + ID_WIDTH'(1);
   endfunction

   rr_priority_pick #(
      .NUM_PORTS (NUM_PORTS),
      .ID_WIDTH  (ID_WIDTH)
   ) u_pick (
      .req       (valid_i),
      .start_ptr (rr_ptr_q),
      .winner    (pick_id),
      .any_req   (any_req)
   );

   // State register: arbitration state, round-robin pointer and lock owner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         rr_ptr_q  <= '0;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         lock_id_q <= lock_id_d;
      end
   end

   // Next-state logic. Only an accepted beat moves the arbiter; a stalled
   // downstream or an idle locked port leaves everything where it is.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      lock_id_d = lock_id_q;
      if (xfer) begin
         unique case (state_q)
            ARB_IDLE: begin
               if (last_o) begin
                  rr_ptr_d = next_port(winner);
               end else begin
                  state_d   = ARB_LOCKED;
                  lock_id_d = winner;
               end
            end
            ARB_LOCKED: begin
               if (last_o) begin
                  state_d  = ARB_IDLE;
                  rr_ptr_d = next_port(lock_id_q);
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   // Output logic. While locked the owner is the only candidate, so other
   // ports are starved even if the owner pauses mid-packet. With no request
   // in idle the picker returns rr_ptr, keeping outputs deterministic.
   always_comb begin
      winner    = (state_q == ARB_LOCKED) ? lock_id_q : pick_id;
      valid_o   = (state_q == ARB_LOCKED) ? valid_i[lock_id_q] : any_req;
      xfer      = valid_o & grant_i;
      data_o    = '0;
      last_o    = 1'b0;
      grant_o   = '0;
      port_id_o = winner;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (winner == ID_WIDTH'(p)) begin
            data_o     = data_i[p*DATA_WIDTH +: DATA_WIDTH];
            last_o     = last_i[p];
            grant_o[p] = xfer;
         end
      end
   end

`ifdef FIFO_ARB_BEAT_CNT_EN
   logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q [NUM_PORTS];

   // Per-port accepted-beat counters. They saturate rather than wrap, and a
   // clear takes priority over a same-cycle transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            beat_cnt_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (cnt_clear_i) begin
               beat_cnt_q[p] <= '0;
            end else if (valid_i[p] && grant_o[p] && (beat_cnt_q[p] != '1)) begin
               beat_cnt_q[p] <= beat_cnt_q[p] + BEAT_CNT_WIDTH'(1);
            end
         end
      end
   end

   // Flatten the counter array onto the packed output bus.
   always_comb begin
      beat_cnt_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         beat_cnt_o[p*BEAT_CNT_WIDTH +: BEAT_CNT_WIDTH] = beat_cnt_q[p];
      end
   end
`endif

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin arbiter that shares one downstream FIFO write port between NUM_PORTS producers using the valid/grant handshake. Multi-beat packets, delimited by a per-port last flag, are kept atomic: once a port wins and transfers a non-last beat, the arbiter locks to it until its last beat is accepted. It sits in front of a generic_fifo instance and drives that FIFO's data_i/valid_i, taking its grant_o as grant_i.

## Interface
- NUM_PORTS, 4, number of requesters (≥2)
- DATA_WIDTH, 32, payload width per beat
- ID_WIDTH, $clog2(NUM_PORTS), width of the port index (localparam)
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- data_i  in  NUM_PORTS*DATA_WIDTH  packed payloads; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH]
- valid_i  in  NUM_PORTS  per-port beat valid
- last_i  in  NUM_PORTS  per-port last-beat-of-packet flag, qualified by valid_i
- grant_o  out  NUM_PORTS  per-port beat accepted
- data_o  out  DATA_WIDTH  selected payload, to FIFO
- valid_o  out  1  beat offered to FIFO
- last_o  out  1  last flag of the selected beat
- port_id_o  out  ID_WIDTH  index of the selected port
- grant_i  in  1  FIFO accepts the beat (FIFO grant_o)

## Operation
- Transfer on port p: valid_i[p] & grant_o[p]. Downstream transfer: valid_o & grant_i.
- State machine, 2 states:
  - IDLE: winner is the first p with valid_i[p]=1, searching p = rr_ptr, rr_ptr+1, … with wrap at NUM_PORTS-1 → 0. valid_o = |valid_i.
  - LOCKED: winner is always lock_id. valid_o = valid_i[lock_id]; other ports are never granted, even when lock_id is idle.
- Outputs: data_o, last_o, port_id_o = winner's values; grant_o[winner] = valid_o & grant_i; all other grant_o bits 0. With no valid request, data_o/last_o are the rr_ptr port's values and port_id_o = rr_ptr (don't-care content, but deterministic).
- On a transfer in IDLE: last=1 → stay IDLE, rr_ptr ← winner+1 (mod NUM_PORTS); last=0 → LOCKED, lock_id ← winner, rr_ptr unchanged.
- On a transfer in LOCKED: last=1 → IDLE, rr_ptr ← lock_id+1 (mod NUM_PORTS); last=0 → stay LOCKED.
- No transfer → state, rr_ptr and lock_id hold.
- Modulo increment is explicit compare-to-(NUM_PORTS-1). Power-of-two overflow is not relied on.
- Producer rules: once valid_i[p] is asserted, data_i and last_i of port p stay stable until granted. The arbiter does not check this.

## Timing
- Zero-latency forwarding. valid_i→valid_o, data_i→data_o and grant_i→grant_o are combinational. The only registered state is state, rr_ptr and lock_id.
- Arbitration decisions take effect the cycle after the transfer that triggers them.
- Reset, asynchronous while rst=1: state=IDLE, rr_ptr=0, lock_id=0. While in reset, grant_o=0 only if valid_i=0 or grant_i=0, because outputs are combinational. The FIFO is reset alongside.
- Reset mid-packet: the lock is dropped and the next packet can come from any port. Recovering the truncated packet is the producer's responsibility.
- Downstream full (grant_i=0): winner is held, no pointer movement.
- Single-beat packets (last=1 on first beat) never enter LOCKED.

## Configuration
- FIFO_ARB_BEAT_CNT_EN, when defined, adds:
  - cnt_clear_i  in  1  synchronous clear of all counters
  - beat_cnt_o  out  NUM_PORTS*16  per-port accepted-beat counters
- Each counter increments on its port's transfer and saturates at 16'hFFFF. Counters reset to 0 on rst. If cnt_clear_i and a transfer occur in the same cycle, the clear wins.
- Undefined: no counter ports, no counter registers. Arbitration behaviour is identical in both cases.

## Structure
- Package fifo_arb_pkg: arb_state_e enum (ARB_IDLE, ARB_LOCKED) and the BEAT_CNT_WIDTH=16 constant.
- One sub-module, rr_priority_pick: combinational, inputs req[NUM_PORTS] and start pointer, outputs winner index and any_req. It is reused by other arbiters.

## Test plan
- Ports 0 and 2 each send continuous single-beat packets, grant_i=1 → grants alternate 0,2,0,2; port_id_o follows.
- After reset, all 4 ports valid with single beats → grant order 0,1,2,3,0.
- Port 1 sends a 3-beat packet (last on beat 3) while port 0 is valid throughout → beats 1,1,1 are contiguous, then port 0 is granted, even with port 1 idle mid-packet for 2 cycles.
- grant_i=0 for 5 cycles with port 3 valid → grant_o=0, valid_o=1, data_o stable; first accepted beat comes from port 3 when grant_i returns.
- rst pulsed while LOCKED on port 2 → next cycle state is IDLE and rr_ptr=0; with ports 0 and 2 valid, port 0 is granted first.
- With FIFO_ARB_BEAT_CNT_EN: port 1 count is preloaded by 65540 transfers → beat_cnt_o[31:16]=16'hFFFF. A cnt_clear_i pulse in the same cycle as a transfer leaves the counter at 0.
